// File: rtl/if_fetch_if.sv
// Pipeline-side bundle of the fetch stage: stall vector, branch redirect from
// ID and the {ce, pc} bus presented to ID.
interface if_fetch_if #(
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic [32:0]        br_bus;
  logic [32:0]        if_to_id_bus;

  // if_to_id_bus[32] (ce) marks the bus as valid; stall[0] is the only
  // back-pressure: while it is Stop, IF holds the bus and ID must not consume it.
  modport master (input stall, input br_bus, output if_to_id_bus);
  modport slave  (output stall, output br_bus, input if_to_id_bus);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, SRAM fetch address and a buffered
// redirect so a branch seen while IF is stalled survives the stall.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          STALL_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_if.master     pipe,
  output logic           inst_sram_en,
  output logic [3:0]     inst_sram_wen,
  output logic [31:0]    inst_sram_addr,
  output logic [31:0]    inst_sram_wdata,
  output logic           fetch_adel,
  output logic           br_pending_o,
  output logic [1:0]     state_dbg_o
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    BR_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        stall_if;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;

  assign stall_if = pipe.stall[0];
  assign br_e     = pipe.br_bus[32];
  assign br_addr  = pipe.br_bus[31:0];

  // A buffered redirect outranks a fresh one from ID.
  assign next_pc = pend_q ? pend_addr_q :
                   br_e   ? br_addr     :
                            pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC - 32'd4;
      ce_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ce_d        = ce_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      BOOT: begin
        if (!stall_if) begin
          ce_d    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall_if) begin
          pc_d = next_pc;
        end else if (br_e) begin
          pend_d      = 1'b1;
          pend_addr_d = br_addr;
          state_d     = BR_HOLD;
        end
      end
      BR_HOLD: begin
        if (stall_if) begin
          // ID still holding the branch re-presents its target.
          if (br_e) pend_addr_d = br_addr;
        end else begin
          pc_d    = next_pc;
          pend_d  = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pipe.if_to_id_bus = {ce_q, pc_q};
  assign inst_sram_en      = ce_q;
  assign inst_sram_wen     = 4'b0000;
  assign inst_sram_addr    = pc_q;
  assign inst_sram_wdata   = 32'd0;
  assign fetch_adel        = ce_q & (pc_q[1:0] != 2'b00);
  assign br_pending_o      = pend_q;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: boot sequence, async reset, redirects with and
// without stall, pending priority/overwrite, misaligned targets and PC wrap.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_adel;
  logic        br_pending_o;
  logic [1:0]  state_dbg_o;

  int checks   = 0;
  int failures = 0;

  if_fetch_if #(.STALL_W(6)) pipe ();

  if_fetch #(.RESET_PC(32'hBFC0_0000), .STALL_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe            (pipe.master),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_adel      (fetch_adel),
    .br_pending_o    (br_pending_o),
    .state_dbg_o     (state_dbg_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar check with immediate assertion
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: bus, sram strobes, adel flag, pending flag
  task automatic chk_out(input string tag, input logic ce, input logic [31:0] pc,
                         input logic adel, input logic pend);
    chk({tag, ".bus"},  {31'd0, pipe.if_to_id_bus}, {31'd0, ce, pc});
    chk({tag, ".en"},   {63'd0, inst_sram_en}, {63'd0, ce});
    chk({tag, ".addr"}, {32'd0, inst_sram_addr}, {32'd0, pc});
    chk({tag, ".adel"}, {63'd0, fetch_adel}, {63'd0, adel});
    chk({tag, ".pend"}, {63'd0, br_pending_o}, {63'd0, pend});
    chk({tag, ".wen"},  {28'd0, inst_sram_wen, inst_sram_wdata}, 64'd0);
  endtask

  // Driver tasks
  task automatic drive(input logic [5:0] st, input logic be, input logic [31:0] ba);
    pipe.stall  = st;
    pipe.br_bus = {be, ba};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(6'b0, 1'b0, 32'd0);
    #12;
    // 1. reset state and boot sequence
    chk_out("rst", 1'b0, 32'hBFBF_FFFC, 1'b0, 1'b0);
    chk("rst.state", {62'd0, state_dbg_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("pre_boot", 1'b0, 32'hBFBF_FFFC, 1'b0, 1'b0);
    step(); chk_out("boot0", 1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    chk("boot.state", {62'd0, state_dbg_o}, 64'd1);
    step(); chk_out("boot1", 1'b1, 32'hBFC0_0004, 1'b0, 1'b0);
    step(); chk_out("boot2", 1'b1, 32'hBFC0_0008, 1'b0, 1'b0);

    // async reset mid-stream
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 32'hBFBF_FFFC, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    step(); chk_out("reboot0", 1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    step(); step(); step(); step();
    chk_out("run10", 1'b1, 32'hBFC0_0010, 1'b0, 1'b0);

    // 2. unstalled redirect, delay slot not squashed
    drive(6'b0, 1'b1, 32'hBFC0_0100);
    step(); chk_out("br100", 1'b1, 32'hBFC0_0100, 1'b0, 1'b0);
    drive(6'b0, 1'b0, 32'd0);
    step(); chk_out("br104", 1'b1, 32'hBFC0_0104, 1'b0, 1'b0);

    // 3. redirect under stall is buffered
    drive(6'b000011, 1'b1, 32'hBFC0_0200);
    step(); chk_out("hold_a", 1'b1, 32'hBFC0_0104, 1'b0, 1'b1);
    chk("hold.state", {62'd0, state_dbg_o}, 64'd2);
    drive(6'b000011, 1'b0, 32'd0);
    step(); step(); step();
    chk_out("hold_b", 1'b1, 32'hBFC0_0104, 1'b0, 1'b1);
    drive(6'b0, 1'b0, 32'd0);
    step(); chk_out("rel200", 1'b1, 32'hBFC0_0200, 1'b0, 1'b0);
    chk("rel.state", {62'd0, state_dbg_o}, 64'd1);

    // 4. pending beats fresh br_e on release; hold overwrites target
    drive(6'b000001, 1'b1, 32'hBFC0_0200);
    step(); chk_out("p4_hold", 1'b1, 32'hBFC0_0200, 1'b0, 1'b1);
    drive(6'b0, 1'b1, 32'hBFC0_0300);
    step(); chk_out("p4_prio", 1'b1, 32'hBFC0_0200, 1'b0, 1'b0);
    drive(6'b000001, 1'b1, 32'hBFC0_0200);
    step();
    drive(6'b000001, 1'b1, 32'hBFC0_0240);
    step(); chk_out("ovr_hold", 1'b1, 32'hBFC0_0200, 1'b0, 1'b1);
    drive(6'b0, 1'b1, 32'hBFC0_0300);
    step(); chk_out("ovr_rel", 1'b1, 32'hBFC0_0240, 1'b0, 1'b0);

    // non-IF stall bits are ignored
    drive(6'b111110, 1'b0, 32'd0);
    step(); chk_out("hi_stall", 1'b1, 32'hBFC0_0244, 1'b0, 1'b0);

    // 5. misaligned target
    drive(6'b0, 1'b1, 32'hBFC0_0402);
    step(); chk_out("mis0", 1'b1, 32'hBFC0_0402, 1'b1, 1'b0);
    drive(6'b0, 1'b0, 32'd0);
    step(); chk_out("mis1", 1'b1, 32'hBFC0_0406, 1'b1, 1'b0);

    // 6. wrap and plain stall
    drive(6'b0, 1'b1, 32'hFFFF_FFFC);
    step(); chk_out("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    drive(6'b0, 1'b0, 32'd0);
    step(); chk_out("wrap1", 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    drive(6'b000001, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("stall4", 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    end
    drive(6'b0, 1'b0, 32'd0);
    step(); chk_out("resume", 1'b1, 32'h0000_0004, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
